// File: rtl/cpu_clock_controller.sv
// rtl/cpu_clock_controller.sv - run/step/halt clock-enable controller for the MIPS core
// Divides Input_Clk to the processor rate and gates it through a run/step/halt FSM.
module cpu_clock_controller #(
    parameter int DIV_HALF        = 25,
    parameter int CNT_W           = 5,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int DB_W            = 16
) (
    input  logic        Input_Clk,
    input  logic        Reset,
    input  logic        Run_Sw,
    input  logic        Step_Btn,
    input  logic        Halt_Req,
    output logic        Cpu_Clk_Out,
    output logic        Cpu_Clk_En,
    output logic [31:0] Cycle_Count,
    output logic [1:0]  State
);

    typedef enum logic [1:0] {
        ST_STOPPED  = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_STEPPING = 2'd2,
        ST_HALTED   = 2'd3
    } state_t;

    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic             cpu_clk_q, cpu_clk_d;
    logic             tick;

    logic             run_meta_q, run_s_q;
    logic             step_meta_q, step_s_q;

    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic             db_level_q, db_level_d;
    logic             step_req_q, step_req_d;

    state_t           state_q, state_d;
    logic             en_q, en_d;
    logic [31:0]      cycle_cnt_q, cycle_cnt_d;

    // Free-running divider; tick marks the edge on which Cpu_Clk_Out rises.
    always_comb begin
        div_cnt_d = div_cnt_q + CNT_W'(1);
        cpu_clk_d = cpu_clk_q;
        if (div_cnt_q == CNT_W'(DIV_HALF - 1)) begin
            div_cnt_d = '0;
            cpu_clk_d = ~cpu_clk_q;
        end
    end

    assign tick = (div_cnt_q == CNT_W'(DIV_HALF - 1)) && !cpu_clk_q;

    always_ff @(posedge Input_Clk or posedge Reset) begin
        if (Reset) begin
            div_cnt_q <= '0;
            cpu_clk_q <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            cpu_clk_q <= cpu_clk_d;
        end
    end

    always_ff @(posedge Input_Clk or posedge Reset) begin
        if (Reset) begin
            run_meta_q  <= 1'b0;
            run_s_q     <= 1'b0;
            step_meta_q <= 1'b0;
            step_s_q    <= 1'b0;
        end else begin
            run_meta_q  <= Run_Sw;
            run_s_q     <= run_meta_q;
            step_meta_q <= Step_Btn;
            step_s_q    <= step_meta_q;
        end
    end

    // The synchronized button must disagree with the accepted level for
    // DEBOUNCE_CYCLES consecutive samples before the level follows it.
    always_comb begin
        db_cnt_d   = '0;
        db_level_d = db_level_q;
        step_req_d = 1'b0;
        if (step_s_q != db_level_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                db_level_d = step_s_q;
                step_req_d = step_s_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    always_ff @(posedge Input_Clk or posedge Reset) begin
        if (Reset) begin
            db_cnt_q   <= '0;
            db_level_q <= 1'b0;
            step_req_q <= 1'b0;
        end else begin
            db_cnt_q   <= db_cnt_d;
            db_level_q <= db_level_d;
            step_req_q <= step_req_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STOPPED: begin
                if (Halt_Req)        state_d = ST_HALTED;
                else if (run_s_q)    state_d = ST_RUNNING;
                else if (step_req_q) state_d = ST_STEPPING;
            end
            ST_RUNNING: begin
                if (Halt_Req)        state_d = ST_HALTED;
                else if (!run_s_q)   state_d = ST_STOPPED;
            end
            ST_STEPPING: begin
                if (Halt_Req)        state_d = ST_HALTED;
                else if (tick)       state_d = ST_STOPPED;
            end
            ST_HALTED: begin
                if (!run_s_q)        state_d = ST_STOPPED;
            end
            default:                 state_d = ST_STOPPED;
        endcase
    end

    always_comb begin
        en_d        = tick && !Halt_Req &&
                      ((state_q == ST_RUNNING) || (state_q == ST_STEPPING));
        cycle_cnt_d = cycle_cnt_q;
        if (en_q) begin
            cycle_cnt_d = cycle_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge Input_Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_STOPPED;
            en_q        <= 1'b0;
            cycle_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            en_q        <= en_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign Cpu_Clk_Out = cpu_clk_q;
    assign Cpu_Clk_En  = en_q;
    assign Cycle_Count = cycle_cnt_q;
    assign State       = state_q;

endmodule

// File: tb/tb_cpu_clock_controller.sv
// tb/tb_cpu_clock_controller.sv - self-checking bench for cpu_clock_controller
module tb_cpu_clock_controller;

    localparam int DC = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run_sw = 1'b0;
    logic        step_btn = 1'b0;
    logic        halt = 1'b0;
    logic        clk_out;
    logic        en;
    logic [31:0] cc;
    logic [1:0]  st;

    always #5 clk = ~clk;

    cpu_clock_controller #(
        .DIV_HALF(25), .CNT_W(5), .DEBOUNCE_CYCLES(DC), .DB_W(4)
    ) dut (
        .Input_Clk(clk), .Reset(rst), .Run_Sw(run_sw), .Step_Btn(step_btn),
        .Halt_Req(halt), .Cpu_Clk_Out(clk_out), .Cpu_Clk_En(en),
        .Cycle_Count(cc), .State(st)
    );

    int n_checks = 0;
    int n_fail = 0;
    int dut_pulses = 0;

    // Reference model: divider phase from edge count, inputs as delay lines,
    // debounce as "last DC samples all disagree with the accepted level".
    int          m_n;
    logic        m_clk, m_en, m_run_a, m_run_s, m_step_a, m_step_s, m_level, m_req;
    logic [1:0]  m_st;
    logic [31:0] m_cnt;
    logic        hist[$];
    int          nn;
    logic        tick, flip, nx_en;
    logic [1:0]  nx_st;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_n = 0; m_clk = 0; m_en = 0; m_cnt = 0; m_st = 0;
            m_run_a = 0; m_run_s = 0; m_step_a = 0; m_step_s = 0;
            m_level = 0; m_req = 0;
            hist.delete();
        end else begin
            nn    = m_n + 1;
            tick  = (nn % 50) == 25;
            nx_en = tick && !halt && (m_st == 2'd1 || m_st == 2'd2);
            case (m_st)
                2'd0:    nx_st = halt ? 2'd3 : m_run_s ? 2'd1 : m_req ? 2'd2 : 2'd0;
                2'd1:    nx_st = halt ? 2'd3 : !m_run_s ? 2'd0 : 2'd1;
                2'd2:    nx_st = halt ? 2'd3 : tick ? 2'd0 : 2'd2;
                default: nx_st = !m_run_s ? 2'd0 : 2'd3;
            endcase
            hist.push_back(m_step_s);
            if (hist.size() > DC) void'(hist.pop_front());
            flip = (hist.size() == DC);
            foreach (hist[i]) if (hist[i] == m_level) flip = 0;
            m_req   = flip && !m_level;
            if (flip) m_level = !m_level;
            m_cnt    = m_cnt + {31'd0, m_en};
            m_en     = nx_en;
            m_st     = nx_st;
            m_n      = nn;
            m_clk    = ((nn / 25) % 2) == 1;
            m_run_s  = m_run_a;
            m_run_a  = run_sw;
            m_step_s = m_step_a;
            m_step_a = step_btn;
        end
        #1;
        if (!rst) begin
            n_checks++;
            if ({clk_out, en, st, cc} !== {m_clk, m_en, m_st, m_cnt}) begin
                n_fail++;
                $display("FAIL cycle_compare t=%0t: got out=%b en=%b st=%0d cnt=%0d expected out=%b en=%b st=%0d cnt=%0d",
                         $time, clk_out, en, st, cc, m_clk, m_en, m_st, m_cnt);
            end
            if (en === 1'b1) dut_pulses++;
        end
    end

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic press(input int hi, input int lo);
        step_btn = 1'b1; cyc(hi);
        step_btn = 1'b0; cyc(lo);
    endtask

    task automatic wait_phase(input int ph, input string nm);
        int b;
        b = 0;
        while ((m_n % 50) != ph && b < 200) begin cyc(1); b++; end
        if (b >= 200) begin n_checks++; n_fail++; $display("FAIL %s: timeout", nm); end
    endtask

    int  base, b;
    bit  seen2;
    logic [0:0] bounce_pat [6];

    initial begin
        // 1: reset, divider alone
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (24) @(posedge clk);
        #1 chk("div_edge24", {31'd0, clk_out}, 32'd0);
        @(posedge clk); #1 chk("div_edge25", {31'd0, clk_out}, 32'd1);
        repeat (25) @(posedge clk);
        #1 chk("div_edge50", {31'd0, clk_out}, 32'd0);
        cyc(100);
        chk("t1_state", {30'd0, st}, 32'd0);
        chk("t1_count", cc, 32'd0);

        // 2: free run for ten pulses
        run_sw = 1'b1;
        cyc(3);
        chk("t2_running", {30'd0, st}, 32'd1);
        b = 0;
        while (dut_pulses < 10 && b < 700) begin cyc(1); b++; end
        chk("t2_pulse_wait", {31'd0, b < 700}, 32'd1);
        cyc(1);
        chk("t2_count10", cc, 32'd10);
        run_sw = 1'b0;
        cyc(4);
        chk("t2_stopped", {30'd0, st}, 32'd0);
        cyc(120);
        chk("t2_no_more", cc, 32'd10);

        // 3: bouncy single step
        bounce_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        seen2 = 0;
        foreach (bounce_pat[i]) begin step_btn = bounce_pat[i]; cyc(1); end
        step_btn = 1'b1;
        for (int i = 0; i < 30; i++) begin cyc(1); if (st == 2'd2) seen2 = 1; end
        step_btn = 1'b0;
        for (int i = 0; i < 90; i++) begin cyc(1); if (st == 2'd2) seen2 = 1; end
        chk("t3_seen_stepping", {31'd0, seen2}, 32'd1);
        chk("t3_state", {30'd0, st}, 32'd0);
        chk("t3_count11", cc, 32'd11);

        // 4: halt exactly on a tick
        run_sw = 1'b1;
        cyc(3);
        chk("t4_running", {30'd0, st}, 32'd1);
        wait_phase(24, "t4_align");
        halt = 1'b1; cyc(1); halt = 1'b0;
        chk("t4_halted", {30'd0, st}, 32'd3);
        chk("t4_no_en", {31'd0, en}, 32'd0);
        press(20, 20);
        chk("t4_step_ignored", {30'd0, st}, 32'd3);
        run_sw = 1'b0;
        cyc(4);
        chk("t4_exit", {30'd0, st}, 32'd0);

        // 5: step ignored while running; run toggle ignored while stepping
        run_sw = 1'b1; cyc(3);
        press(20, 20);
        chk("t5_still_running", {30'd0, st}, 32'd1);
        run_sw = 1'b0; cyc(4);
        chk("t5_stopped", {30'd0, st}, 32'd0);
        wait_phase(26, "t5_align");
        base = dut_pulses;
        step_btn = 1'b1;
        b = 0;
        while (st != 2'd2 && b < 30) begin cyc(1); b++; end
        chk("t5_enter_step", {30'd0, st}, 32'd2);
        run_sw = 1'b1; cyc(3); run_sw = 1'b0;
        step_btn = 1'b0;
        b = 0;
        while (st != 2'd0 && b < 80) begin cyc(1); b++; end
        chk("t5_back_stopped", {30'd0, st}, 32'd0);
        cyc(60);
        chk("t5_one_pulse", dut_pulses - base, 32'd1);
        chk("t5_stay_stopped", {30'd0, st}, 32'd0);

        // random phase
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 299) == 0) run_sw = ~run_sw;
            if ($urandom_range(0, 19) == 0)  step_btn = ~step_btn;
            halt = ($urandom_range(0, 79) == 0);
        end
        halt = 1'b0; run_sw = 1'b0; step_btn = 1'b0;

        // 6: reset mid half-period while running at count 7
        @(negedge clk) rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        run_sw = 1'b1;
        b = 0;
        while (cc != 32'd7 && b < 600) begin cyc(1); b++; end
        chk("t6_count7", cc, 32'd7);
        cyc(10);
        #2 rst = 1'b1;
        #1;
        chk("t6_out", {31'd0, clk_out}, 32'd0);
        chk("t6_en", {31'd0, en}, 32'd0);
        chk("t6_count", cc, 32'd0);
        chk("t6_state", {30'd0, st}, 32'd0);
        run_sw = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc(60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
